// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
//   state_e  : FSM states of mem_arb (IDLE, ADDR, RESP)
//   owner_e  : which requester owns the current transaction (OWN_IFU, OWN_LSU)
//   rr_pick  : round-robin choice between the two requesters
//   rr_reset : last-grant value that makes the preferred requester win first
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // A lone requester wins; with both requesting, the one not granted last wins.
  // With no request the result is don't-care (callers gate it with the request).
  function automatic owner_e rr_pick(logic ifu_req, logic lsu_req, owner_e last);
    if (ifu_req && lsu_req) return (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
    if (lsu_req)            return OWN_LSU;
    return OWN_IFU;
  endfunction

  // Pretend the other requester was granted last so the preferred one goes first.
  function automatic owner_e rr_reset(bit pri_lsu);
    return pri_lsu ? OWN_IFU : OWN_LSU;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of every handshake channel around the arbiter.
//   ifu_* : instruction-fetch request (read only) and response
//   lsu_* : load/store request and response (a write gets one response as ack)
//   bus_* : shared memory request and response channel
// Modports:
//   master : the arbiter's view (it masters the shared bus, serves IFU/LSU)
//   slave  : the environment's view (cores and memory)
interface mem_arb_if #(
  parameter int XLEN = 32
);

  logic              ifu_valid;
  logic              ifu_ready;
  logic [XLEN-1:0]   ifu_addr;
  logic              ifu_rvalid;
  logic [XLEN-1:0]   ifu_rdata;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [XLEN-1:0]   lsu_addr;
  logic              lsu_write;
  logic [XLEN-1:0]   lsu_wdata;
  logic [XLEN/8-1:0] lsu_wstrb;
  logic              lsu_rvalid;
  logic [XLEN-1:0]   lsu_rdata;

  logic              bus_valid;
  logic              bus_ready;
  logic [XLEN-1:0]   bus_addr;
  logic              bus_write;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wstrb;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    input  ifu_valid, ifu_addr,
    output ifu_ready, ifu_rvalid, ifu_rdata,
    input  lsu_valid, lsu_addr, lsu_write, lsu_wdata, lsu_wstrb,
    output lsu_ready, lsu_rvalid, lsu_rdata,
    output bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    output ifu_valid, ifu_addr,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
    output lsu_valid, lsu_addr, lsu_write, lsu_wdata, lsu_wstrb,
    input  lsu_ready, lsu_rvalid, lsu_rdata,
    input  bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/mem_arb_rr_arb2.sv
// Two-input round-robin arbiter holding the last-grant flop.
//   clk, rst          : clock, asynchronous active-high reset
//   ifu_req, lsu_req  : request lines (raw valids)
//   advance           : a grant was accepted this cycle; remember the winner
//   ifu_gnt, lsu_gnt  : one-hot grant, only for a requester that is asking
//   winner            : encoded winner
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter bit PRI_LSU = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ifu_req,
  input  logic   lsu_req,
  input  logic   advance,
  output logic   ifu_gnt,
  output logic   lsu_gnt,
  output owner_e winner
);

  owner_e last_q;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    winner  = rr_pick(ifu_req, lsu_req, last_q);
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (winner == OWN_LSU) lsu_gnt = lsu_req;
    else                   ifu_gnt = ifu_req;
  end

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_q <= rr_reset(PRI_LSU);
    else if (advance) last_q <= winner;
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// memory bus, one transaction outstanding at a time.
//   clk, rst     : clock, asynchronous active-high reset
//   io           : mem_arb_if.master (IFU, LSU and bus channels)
//   err_spurious : sticky, set when bus_rvalid arrives with nothing outstanding
// Flow: IDLE (grant + latch) -> ADDR (bus_valid until bus_ready)
//       -> RESP (wait bus_rvalid, pass it through to the owner) -> IDLE.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit PRI_LSU = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.master io,
  output logic      err_spurious
);

  localparam int SW = XLEN / 8;

  state_e          state;
  owner_e          owner_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            write_q;
  logic [SW-1:0]   wstrb_q;
  logic            bus_valid_q;

  logic            ifu_gnt;
  logic            lsu_gnt;
  owner_e          winner;
  logic            in_idle;
  logic            accept;
  logic            resp_hit;

  // Grants are only offered in IDLE and never while reset is held, even
  // though reset already parks the FSM in IDLE.
  assign in_idle = (state == ST_IDLE) && !rst;
  assign accept  = in_idle && (ifu_gnt || lsu_gnt);

  rr_arb2 #(
    .PRI_LSU (PRI_LSU)
  ) u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .ifu_req (io.ifu_valid),
    .lsu_req (io.lsu_valid),
    .advance (accept),
    .ifu_gnt (ifu_gnt),
    .lsu_gnt (lsu_gnt),
    .winner  (winner)
  );

  assign io.ifu_ready = in_idle && ifu_gnt;
  assign io.lsu_ready = in_idle && lsu_gnt;

  assign io.bus_valid = bus_valid_q;
  assign io.bus_addr  = addr_q;
  assign io.bus_write = write_q;
  assign io.bus_wdata = wdata_q;
  assign io.bus_wstrb = wstrb_q;

  // Response is a same-cycle pass-through, routed only to the owner and only
  // while a transaction is actually waiting for it.
  assign resp_hit      = (state == ST_RESP) && io.bus_rvalid;
  assign io.ifu_rvalid = resp_hit && (owner_q == OWN_IFU);
  assign io.lsu_rvalid = resp_hit && (owner_q == OWN_LSU);
  assign io.ifu_rdata  = io.bus_rdata;
  assign io.lsu_rdata  = io.bus_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner_q      <= OWN_IFU;
      bus_valid_q  <= 1'b0;
      err_spurious <= 1'b0;
      // NOTE: the latched request fields are plain registers, not a memory
      // array, so clearing them on reset is cheap and keeps the idle bus
      // at a known all-zero value.
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      if (io.bus_rvalid && (state != ST_RESP)) err_spurious <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            owner_q     <= winner;
            bus_valid_q <= 1'b1;
            state       <= ST_ADDR;
            if (winner == OWN_LSU) begin
              addr_q  <= io.lsu_addr;
              write_q <= io.lsu_write;
              wdata_q <= io.lsu_wdata;
              wstrb_q <= io.lsu_wstrb;
            end else begin
              addr_q  <= io.ifu_addr;
              write_q <= 1'b0;
              wdata_q <= '0;
              wstrb_q <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (io.bus_ready) begin
            bus_valid_q <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io.bus_rvalid) state <= ST_IDLE;
        end
        default: begin
          bus_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-002 The block SHALL have parameter PRI_LSU, default 1, which selects the requester that wins the first arbitration after reset (1 = LSU, 0 = IFU).
REQ-003 Port clk, input, 1: the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Ports ifu_valid (in, 1), ifu_ready (out, 1), ifu_addr (in, XLEN): instruction fetch request; always a read.
REQ-006 Ports ifu_rvalid (out, 1), ifu_rdata (out, XLEN): instruction fetch response.
REQ-007 Ports lsu_valid (in, 1), lsu_ready (out, 1), lsu_addr (in, XLEN), lsu_write (in, 1), lsu_wdata (in, XLEN), lsu_wstrb (in, XLEN/8): load/store request.
REQ-008 Ports lsu_rvalid (out, 1), lsu_rdata (out, XLEN): load/store response; a write also receives one response as its acknowledge.
REQ-009 Ports bus_valid (out, 1), bus_ready (in, 1), bus_addr (out, XLEN), bus_write (out, 1), bus_wdata (out, XLEN), bus_wstrb (out, XLEN/8): the shared memory request channel.
REQ-010 Ports bus_rvalid (in, 1), bus_rdata (in, XLEN): the shared memory response channel.
REQ-011 Port err_spurious, output, 1: sticky flag that is set when bus_rvalid arrives while no transaction is outstanding.

Function
REQ-012 The block SHALL use a three-state FSM with states IDLE, ADDR and RESP.
REQ-013 In IDLE, the block SHALL assert exactly one of ifu_ready/lsu_ready, combinationally, for the arbitration winner, and only if that requester's valid is high.
REQ-014 Arbitration SHALL be round-robin:
- A requester that is the only one valid wins.
- When both are valid, the requester not granted last wins.
- The last-grant register SHALL reset so that the requester selected by PRI_LSU wins first.
REQ-015 On the accepting handshake (valid && ready), the block SHALL:
- latch the address, write, wdata and wstrb fields (write=0 and wstrb=0 for IFU);
- latch the owner;
- update last-grant;
- move to ADDR.
REQ-016 In ADDR, bus_valid SHALL be 1 and bus_* fields SHALL equal the latched values, held stable until bus_ready is sampled high; the block then moves to RESP.
REQ-017 In RESP, bus_valid SHALL be 0; when bus_rvalid is high, the block SHALL drive the owner's *_rvalid=1 and *_rdata=bus_rdata in the same cycle (combinational pass-through), then return to IDLE.
REQ-018 The non-owner's rvalid SHALL be 0 at all times.
REQ-019 Only one transaction SHALL be outstanding; both *_ready outputs SHALL be 0 in ADDR and RESP.
REQ-020 Minimum latency SHALL be as follows (cycle 0 = accept):
- bus_valid in cycle 1;
- with bus_ready=1 in cycle 1, RESP in cycle 2;
- with bus_rvalid in cycle 2, the response is returned in cycle 2;
- the next accept is possible in cycle 3.
REQ-021 When bus_rvalid=1 in IDLE or ADDR, the block SHALL ignore it for routing and SHALL set err_spurious, which then stays set until reset.
REQ-022 A requester that deasserts valid before being granted SHALL lose nothing; the request is simply not accepted.

Reset
REQ-023 Assertion of rst at any time, including mid-transaction, SHALL asynchronously force:
- state=IDLE;
- bus_valid=0, ifu_rvalid=0, lsu_rvalid=0;
- err_spurious=0;
- latched fields=0;
- last-grant to its PRI_LSU reset value.
REQ-024 A transaction aborted by reset SHALL NOT produce a response after reset is released; the external bus is reset by the same rst.
REQ-025 During reset, ifu_ready and lsu_ready SHALL be 0.

Structure
REQ-026 The FSM state enum and the owner encoding (OWN_IFU, OWN_LSU) SHALL live in a shared core package.
REQ-027 A sub-module rr_arb2 (two-input round-robin arbiter holding the last-grant flop) SHALL implement REQ-014; all other logic SHALL be in mem_arb.

Verification
REQ-028 IFU-only read: ifu_valid=1, ifu_addr=0x80000000, bus_ready=1, bus_rvalid next cycle with rdata=0x00100073 -> ifu_ready at cycle 0, bus_valid at cycle 1, ifu_rvalid=1 with rdata=0x00100073 at cycle 2, lsu_rvalid=0 throughout.
REQ-029 Simultaneous requests, repeated four times with both valids held high and PRI_LSU=1 -> grant order LSU, IFU, LSU, IFU.
REQ-030 LSU write addr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF, with bus_ready held low for 3 cycles -> bus_* fields stable across all 4 ADDR cycles, then a single lsu_rvalid acknowledge.
REQ-031 bus_rvalid pulsed in IDLE -> no *_rvalid asserted, err_spurious=1 and held across later normal transactions.
REQ-032 rst asserted in RESP before bus_rvalid -> all outputs 0 immediately; after release, the first IFU request completes normally.
